multiplier_sequencer: RTL and testbench

MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

---
 rtl/multiplier_sequencer_pkg.sv | 12 +
 rtl/fourBitAdder.sv | 21 ++
 rtl/multiplier_sequencer.sv | 97 +++++++++
 tb/tb_multiplier_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_sequencer_pkg.sv
// rtl/multiplier_sequencer_pkg.sv - shared state encoding and default width for the shift-add multiplier
package multiplier_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/fourBitAdder.sv
// rtl/fourBitAdder.sv - 4-bit ripple-carry adder with carry-in and carry-out
module fourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/multiplier_sequencer.sv
// rtl/multiplier_sequencer.sv - sequential shift-add unsigned multiplier, fixed WIDTH-cycle run
module multiplier_sequencer
  import multiplier_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mul_state_t         state_q, state_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   sum_hi;
  logic               sum_carry;
  logic [2*WIDTH:0]   acc_added;

  // Upper accumulator half plus multiplicand; carry lands in the guard bit.
  if (WIDTH == 4) begin : g_add4
    fourBitAdder u_add (
      .a    (acc_q[2*WIDTH-1:WIDTH]),
      .b    (mcand_q),
      .cin  (1'b0),
      .sum  (sum_hi),
      .cout (sum_carry)
    );
  end else begin : g_addn
    assign {sum_carry, sum_hi} = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  end

  assign acc_added = acc_q[0] ? {sum_carry, sum_hi, acc_q[WIDTH-1:0]} : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          acc_d   = {{(WIDTH + 1){1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_added >> 1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_sequencer.sv
// tb/tb_multiplier_sequencer.sv - directed self-checking bench for multiplier_sequencer at default width
module tb_multiplier_sequencer;
  import multiplier_sequencer_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int checks = 0;
  int errors = 0;

  multiplier_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Offer one pair for one cycle; count edges until out_valid (edge 1 is the transfer).
  task automatic start_and_wait(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output int lat, output logic busy_ok, output logic [2*W-1:0] prod);
    @(negedge clk);
    a_i = av;
    b_i = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      a_i = W'($urandom_range(0, (1 << W) - 1));
      b_i = W'($urandom_range(0, (1 << W) - 1));
      lat++;
      if (!busy) busy_ok = 1'b0;
    end while (!out_valid && lat < 20);
    prod = p;
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_i = '0;
    b_i = '0;
    #23;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b p=%0d required 1 0 0 0",
               in_ready, out_valid, busy, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic bok; logic [2*W-1:0] prod;
    start_and_wait(4'd13, 4'd11, lat, bok, prod);
    checks++;
    if (prod !== 8'd143) begin
      errors++; $display("FAIL basic_product got %0d required 143", prod);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency got %0d required 5", lat);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b required 1", bok);
    end
    accept_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0]   av [3] = '{4'd15, 4'd0, 4'd9};
    logic [W-1:0]   bv [3] = '{4'd15, 4'd9, 4'd0};
    logic [2*W-1:0] ev [3] = '{8'd225, 8'd0, 8'd0};
    int lat; logic bok; logic [2*W-1:0] prod;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(av[i], bv[i], lat, bok, prod);
      checks++;
      if (prod !== ev[i] || lat !== 5) begin
        errors++;
        $display("FAIL extreme_%0d p=%0d lat=%0d required p=%0d lat=5", i, prod, lat, ev[i]);
      end
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic bok; logic [2*W-1:0] prod;
    int bad = 0;
    start_and_wait(4'd7, 4'd6, lat, bok, prod);
    checks++;
    if (prod !== 8'd42) begin
      errors++; $display("FAIL bp_product got %0d required 42", prod);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_i = W'(i);
      if (p !== 8'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_hold unstable_cycles=%0d required 0", bad);
    end
    accept_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b required 1 0 0",
                         in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic bok; logic [2*W-1:0] prod;
    @(negedge clk);
    a_i = 4'd12;
    b_i = 4'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_run out_valid=%b p=%0d busy=%b in_ready=%b required 0 0 0 1",
               out_valid, p, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_and_wait(4'd3, 4'd3, lat, bok, prod);
    checks++;
    if (prod !== 8'd9 || lat !== 5) begin
      errors++; $display("FAIL rst_next_op p=%0d lat=%0d required p=9 lat=5", prod, lat);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] q[$];
    int last = -1;
    int n = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected p=%0d required no result", p);
        end else begin
          if (p !== q[0]) begin
            errors++; $display("FAIL b2b_product got %0d required %0d", p, q[0]);
          end
          void'(q.pop_front());
        end
        if (last >= 0) begin
          checks++;
          if (k - last !== 6) begin
            errors++; $display("FAIL b2b_spacing got %0d required 6", k - last);
          end
        end
        last = k;
        n++;
      end
      if (k < 60) begin
        a_i = W'($urandom_range(0, (1 << W) - 1));
        b_i = W'($urandom_range(0, (1 << W) - 1));
        in_valid = 1'b1;
        if (in_ready) q.push_back({4'd0, a_i} * {4'd0, b_i});
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (q.size() !== 0 || n < 9) begin
      errors++; $display("FAIL b2b_count pending=%0d results=%0d required 0 and >=9", q.size(), n);
    end
  endtask

  task automatic test_exhaustive();
    int lat; logic bok; logic [2*W-1:0] prod;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        start_and_wait(W'(i), W'(j), lat, bok, prod);
        checks++;
        if (prod !== 8'(i * j) || lat !== 5) begin
          errors++;
          $display("FAIL exhaustive a=%0d b=%0d p=%0d lat=%0d required p=%0d lat=5", i, j, prod, lat, i * j);
        end
        accept_result();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
